mux_scan_serializer: RTL



---
 rtl/mux_scan_serializer.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_scan_serializer.sv
// Parallel-to-serial front end for the 8:1 data selector: holds a byte on the selector and scans its address.
// Define SERIALIZER_PARITY_EN to append an even-parity bit (9-bit frame).
module mux_scan_serializer #(
    parameter int MSB_FIRST  = 0,
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] load_dat,
    input  logic       load_valid,
    output logic       load_ready,
    output logic [7:0] sel_dat,
    output logic [2:0] sel_addr,
    input  logic       sel_out,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy
);

    localparam int DIV_W = $clog2(BIT_CYCLES) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIALIZER_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif

    logic [1:0]       state;
    logic [DIV_W-1:0] div;
    logic [2:0]       bitcnt;
`ifdef SERIALIZER_PARITY_EN
    logic             par;
`endif

    // Address walk direction; wraps modulo 8 after the last bit.
    function automatic logic [2:0] next_addr(input logic [2:0] a);
        return (MSB_FIRST != 0) ? a - 3'd1 : a + 3'd1;
    endfunction

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_dat   <= '0;
            sel_addr  <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            div       <= '0;
            bitcnt    <= '0;
`ifdef SERIALIZER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        sel_dat  <= load_dat;
                        sel_addr <= (MSB_FIRST != 0) ? 3'd7 : 3'd0;
                        div      <= '0;
                        bitcnt   <= '0;
                        state    <= SHIFT;
`ifdef SERIALIZER_PARITY_EN
                        par      <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // Capture at the end of each bit period so sel_out has settled for BIT_CYCLES clocks.
                    if (div == DIV_LAST) begin
                        ser_out   <= sel_out;
                        ser_valid <= 1'b1;
                        div       <= '0;
                        bitcnt    <= bitcnt + 3'd1;
                        sel_addr  <= next_addr(sel_addr);
`ifdef SERIALIZER_PARITY_EN
                        par       <= par ^ sel_out;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
`else
                        if (bitcnt == 3'd7) begin
                            ser_last <= 1'b1;
                            state    <= IDLE;
                        end
`endif
                    end else begin
                        div <= div + 1'b1;
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PARITY: begin
                    if (div == DIV_LAST) begin
                        ser_out   <= par;
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b1;
                        div       <= '0;
                        state     <= IDLE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
